uart_rx_ip: RTL and testbench

Memory-mapped UART receiver peripheral on the SoC local bus, the inbound counterpart of the existing UART transmitter. It deserialises 8N1 frames from the `i_uart_rx` pin, buffers received bytes in a small FIFO and exposes them to FemtoRV32 through the same local-bus CSR protocol used by the GPIO and UART TX blocks. Its `rdata` feeds the top-level read mux under a new device-select line, and `o_irq` is available for future interrupt use.

---
 rtl/uart_rx_ip.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_rx_ip.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver with an RX FIFO and a small CSR block.
// Registers: 0x0 DATA (pop on read), 0x4 STATUS (overrun/frame_err are W1C), 0x8 LEVEL.
module uart_rx_ip #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        i_uart_rx,
  output logic        o_irq
);

  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [3:0] OffData   = 4'h0;
  localparam logic [3:0] OffStatus = 4'h4;
  localparam logic [3:0] OffLevel  = 4'h8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q;

  // Two-flop synchroniser; both stages reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            cnt_expired;
  logic            push_req;
  logic            frame_set;

  assign cnt_expired = (cnt_q == '0);

  // Next-state logic: baud counter counts down to 0, each expiry is a sample point.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          cnt_d   = CntHalf;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_expired) begin
          if (!rx_s_q) begin
            cnt_d   = CntFull;
            bit_d   = 3'd0;
            state_d = StData;
          end else begin
            // Start bit gone by its midpoint: a glitch, not a frame.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StData: begin
        if (cnt_expired) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = CntFull;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStop: begin
        if (cnt_expired) begin
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = StIdle;
          end else begin
            frame_set = 1'b1;
            state_d   = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWaitHigh: begin
        // Hold off until the line returns high so a break cannot look like a start bit.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] level;
  logic            fifo_empty, fifo_full;
  logic            pop, push, overrun_set;
  logic [7:0]      head_byte;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign level      = wr_ptr_q - rd_ptr_q;
  assign head_byte  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign pop         = ren && (raddr[3:0] == OffData) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push        = push_req && (!fifo_full || pop);
  assign overrun_set = push_req && fifo_full && !pop;

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
    end
  end

  // ---------------------------------------------------------------------------
  // CSR block
  // ---------------------------------------------------------------------------
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        wready_q, wready_d;
  logic        status_wr;

  assign status_wr = wen && wstrb[0] && (waddr[3:0] == OffStatus);

  // Sticky flags: a set event in the same cycle as a W1C clear wins.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (status_wr && wdata[2]) begin
      overrun_d = 1'b0;
    end
    if (status_wr && wdata[3]) begin
      frame_err_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (frame_set) begin
      frame_err_d = 1'b1;
    end
  end

  // Read mux and bus handshakes; rdata holds between reads.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ren;
    wready_d = wen;
    if (ren) begin
      case (raddr[3:0])
        OffData:   rdata_d = fifo_empty ? 32'h0 : {24'h0, head_byte};
        OffStatus: rdata_d = {28'h0, frame_err_q, overrun_q, fifo_full, !fifo_empty};
        OffLevel:  rdata_d = {{(32 - PtrW){1'b0}}, level};
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  // CSR and bus response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= 32'h0;
      rvalid_q    <= 1'b0;
      wready_q    <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      wready_q    <= wready_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wready = wready_q;
  assign o_irq  = !fifo_empty;

  // Address/data bits outside the decoded fields.
  logic unused_bits;
  assign unused_bits = ^{waddr[31:4], wdata[31:4], wdata[1:0], wstrb[3:1], raddr[31:4]};

endmodule

// File: tb/tb_uart_rx_ip.sv
// Testbench for uart_rx_ip: byte-level model of the FIFO/flags, reads scored through a queue.
module tb_uart_rx_ip;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] waddr, wdata, raddr;
  logic        wen, ren;
  logic [3:0]  wstrb;
  logic        wready, rvalid, o_irq;
  logic [31:0] rdata;
  logic        rx_pin;

  uart_rx_ip #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .waddr    (waddr),
    .wdata    (wdata),
    .wen      (wen),
    .wstrb    (wstrb),
    .wready   (wready),
    .raddr    (raddr),
    .ren      (ren),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .i_uart_rx(rx_pin),
    .o_irq    (o_irq)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference model of the receive side.
  logic [7:0]  model_q[$];
  logic        m_ovr  = 1'b0;
  logic        m_ferr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {28'h0, m_ferr, m_ovr, (model_q.size() == Depth), (model_q.size() != 0)};
  endfunction

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) begin
      m_ferr = 1'b1;
    end else if (model_q.size() == Depth) begin
      m_ovr = 1'b1;
    end else begin
      model_q.push_back(b);
    end
  endtask

  // Scoreboard side: every rvalid pulse retires the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      check_eq("pending_reads", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
        check_eq(tag_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // Callers enter 1 time unit after a rising edge; the task returns likewise.
  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    raddr = {28'h0, a};
    ren   = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1 ren = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rvalid"}, {31'h0, rvalid}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_rvalid_fall"}, {31'h0, rvalid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] b;
    b = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
    rd(4'h0, {24'h0, b}, tag);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string tag);
    waddr = {28'h0, a};
    wdata = d;
    wstrb = 4'hf;
    wen   = 1'b1;
    @(posedge clk);
    #1 wen = 1'b0;
    @(negedge clk);
    check_eq({tag, "_wready"}, {31'h0, wready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; a zero stop bit leaves the line low for the caller to release.
  task automatic send(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (Cpb) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_pin = b[i];
      repeat (Cpb) @(posedge clk);
    end
    #1 rx_pin = stop;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] first;
    rst    = 1'b1;
    rx_pin = 1'b1;
    waddr  = 32'h0;
    wdata  = 32'h0;
    raddr  = 32'h0;
    wen    = 1'b0;
    ren    = 1'b0;
    wstrb  = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_irq", {31'h0, o_irq}, 32'd0);
    rd(4'h4, 32'h0, "rst_status");
    rd(4'h8, 32'h0, "rst_level");

    // Single frame
    send(8'hA5, 1'b1);
    model_rx(8'hA5, 1'b1);
    idle(3);
    check_eq("single_irq", {31'h0, o_irq}, 32'd1);
    rd(4'h8, 32'(model_q.size()), "single_level");
    rd_data("single_data");
    check_eq("single_irq_fall", {31'h0, o_irq}, 32'd0);
    rd(4'h4, exp_status(), "single_status");

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      model_rx(8'(i), 1'b1);
    end
    idle(3);
    rd(4'h8, 32'(model_q.size()), "ovr_level");
    rd(4'h4, exp_status(), "ovr_status");
    for (int i = 0; i < 4; i++) begin
      rd_data("ovr_data");
    end
    rd(4'h4, exp_status(), "ovr_status_drained");
    wr(4'h4, 32'h4, "ovr_clear");
    m_ovr = 1'b0;
    rd(4'h4, exp_status(), "ovr_status_cleared");

    // Framing error, line break, then a good frame
    send(8'h3C, 1'b0);
    model_rx(8'h3C, 1'b0);
    idle(20 * Cpb);
    rx_pin = 1'b1;
    idle(8);
    send(8'h55, 1'b1);
    model_rx(8'h55, 1'b1);
    idle(3);
    rd(4'h4, exp_status(), "ferr_status");
    rd(4'h8, 32'(model_q.size()), "ferr_level");
    rd_data("ferr_data");
    wr(4'h4, 32'h8, "ferr_clear");
    m_ferr = 1'b0;
    rd(4'h4, exp_status(), "ferr_status_cleared");

    // One-cycle glitch while idle
    @(posedge clk);
    #1 rx_pin = 1'b0;
    @(posedge clk);
    #1 rx_pin = 1'b1;
    idle(12);
    rd(4'h8, 32'(model_q.size()), "glitch_level");
    rd(4'h4, exp_status(), "glitch_status");
    send(8'h5A, 1'b1);
    model_rx(8'h5A, 1'b1);
    idle(3);
    rd_data("glitch_then_frame");

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i), 1'b1);
      model_rx(8'h10 + 8'(i), 1'b1);
    end
    idle(3);
    rd(4'h8, 32'(model_q.size()), "pp_level_full");
    first = model_q.pop_front();
    fork
      send(8'h14, 1'b1);
      begin
        // The stop bit is sampled on the 41st rising edge after the frame starts.
        @(posedge clk);
        repeat (40) @(posedge clk);
        #1;
        rd(4'h0, {24'h0, first}, "pp_data");
      end
    join
    model_q.push_back(8'h14);
    idle(3);
    rd(4'h8, 32'(model_q.size()), "pp_level");
    rd(4'h4, exp_status(), "pp_status");
    for (int i = 0; i < 4; i++) begin
      rd_data("pp_order");
    end
    rd(4'h0, 32'h0, "empty_data");

    idle(2);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
